// File: rtl/ysyx_25020047_exec_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle execution sequencer.
package ysyx_25020047_exec_ctrl_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned CNT_W_DEF = 32;

  localparam logic [INST_W-1:0] INST_EBREAK = 32'h4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_ABORT = 3'd6
  } state_t;

  // True when exactly one bit of the instruction class is set.
  function automatic logic is_onehot(input logic [INST_W-1:0] v);
    return (v != '0) && ((v & (v - INST_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ysyx_25020047_exec_ctrl_wdt.sv
// Wait-cycle watchdog: counts cycles spent waiting for a response, flags the last allowed one.
module ysyx_25020047_exec_ctrl_wdt #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // Expired on the LIMIT-th waiting cycle so the FSM leaves exactly then.
  assign expired_c = (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/ysyx_25020047_exec_ctrl.sv
// Multi-cycle sequencer: fetch -> exec -> mem -> writeback around the EXU, with halt/abort and perf counters.
module ysyx_25020047_exec_ctrl
  import ysyx_25020047_exec_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INST_W-1:0]  inst_type,
  input  logic               exu_reg_wen,
  input  logic               exu_read,
  input  logic               exu_write,
  output logic               ifu_req,
  input  logic               ifu_rvalid,
  output logic               lsu_req,
  output logic               lsu_wen,
  input  logic               lsu_rvalid,
  output logic               rf_wen,
  output logic               pc_wen,
  output logic               halt,
  output logic               abort,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  state_t state_q, state_d;
  logic   reg_wen_q, reg_wen_d;
  logic   lsu_wen_d;
  logic   waiting_c;
  logic   wdt_expired_c;

  assign state     = state_q;
  assign waiting_c = (state_q == ST_FETCH) || (state_q == ST_MEM);

  ysyx_25020047_exec_ctrl_wdt #(
    .LIMIT (TIMEOUT)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .clr       (!waiting_c),
    .en        (waiting_c),
    .expired_c (wdt_expired_c)
  );

  // Next-state and latched EXU decisions.
  always_comb begin
    state_d   = state_q;
    reg_wen_d = reg_wen_q;
    lsu_wen_d = lsu_wen;
    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (ifu_rvalid)         state_d = ST_EXEC;
        else if (wdt_expired_c) state_d = ST_ABORT;
      end
      ST_EXEC: begin
        reg_wen_d = exu_reg_wen;
        if (!is_onehot(inst_type))       state_d = ST_ABORT;
        else if (inst_type == INST_EBREAK) state_d = ST_HALT;
        else if (exu_read && exu_write)  state_d = ST_ABORT;
        else if (exu_read || exu_write) begin
          state_d   = ST_MEM;
          lsu_wen_d = exu_write;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (lsu_rvalid)         state_d = ST_WB;
        else if (wdt_expired_c) state_d = ST_ABORT;
      end
      ST_WB:    state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      ST_ABORT: state_d = ST_ABORT;
      default:  state_d = ST_ABORT;
    endcase
  end

  // State, outputs registered from the next state, and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      reg_wen_q   <= 1'b0;
      lsu_wen     <= 1'b0;
      ifu_req     <= 1'b0;
      lsu_req     <= 1'b0;
      rf_wen      <= 1'b0;
      pc_wen      <= 1'b0;
      halt        <= 1'b0;
      abort       <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state_q   <= state_d;
      reg_wen_q <= reg_wen_d;
      lsu_wen   <= lsu_wen_d;
      ifu_req   <= (state_d == ST_FETCH);
      lsu_req   <= (state_d == ST_MEM);
      rf_wen    <= (state_d == ST_WB) && reg_wen_d;
      pc_wen    <= (state_d == ST_WB);
      halt      <= (state_d == ST_HALT);
      abort     <= (state_d == ST_ABORT);
      if ((state_q != ST_HALT) && (state_q != ST_ABORT)) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (state_q == ST_WB) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_exec_ctrl.sv
// Directed bench for the execution sequencer: vector table plus reset/timeout sequences.
module tb_ysyx_25020047_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_type;
  logic        exu_reg_wen, exu_read, exu_write;
  logic        ifu_req, ifu_rvalid, lsu_req, lsu_wen, lsu_rvalid;
  logic        rf_wen, pc_wen, halt, abort;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        to_rst;
  logic [31:0] to_inst;
  logic        to_read, to_ifu_rvalid, to_lsu_rvalid;
  logic        to_ifu_req, to_lsu_req, to_lsu_wen, to_rf_wen, to_pc_wen, to_halt, to_abort;
  logic [2:0]  to_state;
  logic [31:0] to_cycle_cnt, to_instret_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25020047_exec_ctrl u_dut (
    .clk (clk), .rst (rst), .inst_type (inst_type),
    .exu_reg_wen (exu_reg_wen), .exu_read (exu_read), .exu_write (exu_write),
    .ifu_req (ifu_req), .ifu_rvalid (ifu_rvalid),
    .lsu_req (lsu_req), .lsu_wen (lsu_wen), .lsu_rvalid (lsu_rvalid),
    .rf_wen (rf_wen), .pc_wen (pc_wen), .halt (halt), .abort (abort),
    .state (state), .cycle_cnt (cycle_cnt), .instret_cnt (instret_cnt)
  );

  ysyx_25020047_exec_ctrl #(.TIMEOUT(4)) u_to (
    .clk (clk), .rst (to_rst), .inst_type (to_inst),
    .exu_reg_wen (1'b1), .exu_read (to_read), .exu_write (1'b0),
    .ifu_req (to_ifu_req), .ifu_rvalid (to_ifu_rvalid),
    .lsu_req (to_lsu_req), .lsu_wen (to_lsu_wen), .lsu_rvalid (to_lsu_rvalid),
    .rf_wen (to_rf_wen), .pc_wen (to_pc_wen), .halt (to_halt), .abort (to_abort),
    .state (to_state), .cycle_cnt (to_cycle_cnt), .instret_cnt (to_instret_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic        wen, rd, wr;
    int          delay;
    logic        spam;
    int          st, rf, pc, pck, lsu, lwen, hlt, abt, ret, cyc;
  } vec_t;

  localparam int NV = 11;
  localparam int NCYC = 14;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_type = '0; exu_reg_wen = 0; exu_read = 0; exu_write = 0;
    ifu_rvalid = 0; lsu_rvalid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int rf_n, pc_n, pc_k, lsu_n, lwen_seen, mem_idx;
    bit fetched;
    v = vecs[i];
    rf_n = 0; pc_n = 0; pc_k = 0; lsu_n = 0; lwen_seen = 0; mem_idx = 0; fetched = 0;
    do_reset();
    inst_type = v.inst; exu_reg_wen = v.wen; exu_read = v.rd; exu_write = v.wr;
    for (int k = 1; k <= NCYC; k++) begin
      tick();
      chk($sformatf("v%0d k%0d halt&abort", i, k), 32'(halt & abort), 32'd0);
      if (halt || abort)
        chk($sformatf("v%0d k%0d quiet", i, k), 32'(rf_wen | pc_wen | ifu_req | lsu_req), 32'd0);
      if (rf_wen) rf_n++;
      if (pc_wen) begin pc_n++; if (pc_k == 0) pc_k = k; end
      if (lsu_req) begin lsu_n++; if (lsu_wen) lwen_seen = 1; end
      ifu_rvalid = (ifu_req && !fetched) || (v.spam && fetched);
      if (ifu_req && !fetched) fetched = 1;
      if (lsu_req) begin
        lsu_rvalid = (mem_idx == v.delay);
        mem_idx++;
      end else begin
        lsu_rvalid = v.spam;
      end
    end
    chk($sformatf("v%0d state", i), 32'(state), 32'(v.st));
    chk($sformatf("v%0d rf_cnt", i), 32'(rf_n), 32'(v.rf));
    chk($sformatf("v%0d pc_cnt", i), 32'(pc_n), 32'(v.pc));
    chk($sformatf("v%0d pc_cycle", i), 32'(pc_k), 32'(v.pck));
    chk($sformatf("v%0d lsu_cycles", i), 32'(lsu_n), 32'(v.lsu));
    chk($sformatf("v%0d lsu_wen", i), 32'(lwen_seen), 32'(v.lwen));
    chk($sformatf("v%0d halt", i), 32'(halt), 32'(v.hlt));
    chk($sformatf("v%0d abort", i), 32'(abort), 32'(v.abt));
    chk($sformatf("v%0d instret", i), instret_cnt, 32'(v.ret));
    chk($sformatf("v%0d cycle_cnt", i), cycle_cnt, 32'(v.cyc));
  endtask

  initial begin
    //            inst          wen rd wr dly spam st rf pc pck lsu lwen hlt abt ret cyc
    vecs[0]  = '{32'h1,         1, 0, 0, 0, 0,   1, 1, 1, 3,  0,  0,   0,  0,  1,  14};
    vecs[1]  = '{32'h20,        1, 1, 0, 5, 0,   1, 1, 1, 9,  6,  0,   0,  0,  1,  14};
    vecs[2]  = '{32'h80,        0, 0, 1, 0, 0,   1, 0, 1, 4,  1,  1,   0,  0,  1,  14};
    vecs[3]  = '{32'h20,        1, 1, 0, 1, 0,   1, 1, 1, 5,  2,  0,   0,  0,  1,  14};
    vecs[4]  = '{32'h4,         0, 0, 0, 0, 1,   5, 0, 0, 0,  0,  0,   1,  0,  0,  3};
    vecs[5]  = '{32'h3,         1, 0, 0, 0, 1,   6, 0, 0, 0,  0,  0,   0,  1,  0,  3};
    vecs[6]  = '{32'h0,         1, 0, 0, 0, 1,   6, 0, 0, 0,  0,  0,   0,  1,  0,  3};
    vecs[7]  = '{32'h20,        1, 1, 1, 0, 1,   6, 0, 0, 0,  0,  0,   0,  1,  0,  3};
    vecs[8]  = '{32'h4,         1, 1, 1, 0, 1,   5, 0, 0, 0,  0,  0,   1,  0,  0,  3};
    vecs[9]  = '{32'h2,         0, 0, 0, 0, 0,   1, 0, 1, 3,  0,  0,   0,  0,  1,  14};
    vecs[10] = '{32'h80000000,  1, 0, 0, 0, 0,   1, 1, 1, 3,  0,  0,   0,  0,  1,  14};

    rst = 1; to_rst = 1;
    clear_inputs();
    to_inst = 32'h1; to_read = 0; to_ifu_rvalid = 0; to_lsu_rvalid = 0;
    ifu_rvalid = 1;
    tick(); tick();
    chk("reset state", 32'(state), 32'd0);
    chk("reset ifu_req", 32'(ifu_req), 32'd0);
    chk("reset lsu_req", 32'(lsu_req), 32'd0);
    chk("reset lsu_wen", 32'(lsu_wen), 32'd0);
    chk("reset rf_wen", 32'(rf_wen), 32'd0);
    chk("reset pc_wen", 32'(pc_wen), 32'd0);
    chk("reset halt", 32'(halt), 32'd0);
    chk("reset abort", 32'(abort), 32'd0);
    chk("reset cycle_cnt", cycle_cnt, 32'd0);
    chk("reset instret", instret_cnt, 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // addi retires, then a load is reset while waiting in MEM
    do_reset();
    inst_type = 32'h1; exu_reg_wen = 1;
    tick(); ifu_rvalid = 1;
    tick(); ifu_rvalid = 0;
    tick();
    chk("seq wb pc_wen", 32'(pc_wen), 32'd1);
    chk("seq wb rf_wen", 32'(rf_wen), 32'd1);
    tick(); inst_type = 32'h20; exu_read = 1; ifu_rvalid = 1;
    tick(); ifu_rvalid = 0;
    tick();
    chk("seq mem state", 32'(state), 32'd3);
    chk("seq mem lsu_req", 32'(lsu_req), 32'd1);
    tick();
    chk("seq mem instret", instret_cnt, 32'd1);
    chk("seq mem cycle_cnt", cycle_cnt, 32'd7);
    rst = 1;
    tick();
    chk("seq rst state", 32'(state), 32'd0);
    chk("seq rst lsu_req", 32'(lsu_req), 32'd0);
    chk("seq rst rf/pc", 32'(rf_wen | pc_wen), 32'd0);
    chk("seq rst cycle_cnt", cycle_cnt, 32'd0);
    chk("seq rst instret", instret_cnt, 32'd0);
    rst = 0;

    // TIMEOUT=4: fetch never answered
    tick(); to_rst = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("to fetch k%0d state", k), 32'(to_state), 32'd1);
      chk($sformatf("to fetch k%0d abort", k), 32'(to_abort), 32'd0);
    end
    tick();
    chk("to fetch abort", 32'(to_abort), 32'd1);
    chk("to fetch ifu_req", 32'(to_ifu_req), 32'd0);
    chk("to fetch cycle_cnt", to_cycle_cnt, 32'd5);
    to_ifu_rvalid = 1;
    tick(); tick();
    chk("to abort absorbing", 32'(to_state), 32'd6);
    chk("to cycle frozen", to_cycle_cnt, 32'd5);

    // TIMEOUT=4: load unanswered in MEM, then answered on the last allowed cycle
    for (int pass = 0; pass < 2; pass++) begin
      to_rst = 1; to_ifu_rvalid = 0; to_lsu_rvalid = 0; to_inst = 32'h20; to_read = 1;
      tick(); to_rst = 0;
      tick(); to_ifu_rvalid = 1;
      tick(); to_ifu_rvalid = 0;
      for (int k = 1; k <= 4; k++) begin
        tick();
        chk($sformatf("to mem p%0d k%0d lsu_req", pass, k), 32'(to_lsu_req), 32'd1);
        if (k == 4) to_lsu_rvalid = (pass == 1);
      end
      tick();
      to_lsu_rvalid = 0;
      chk($sformatf("to mem p%0d state", pass), 32'(to_state), (pass == 1) ? 32'd4 : 32'd6);
      chk($sformatf("to mem p%0d abort", pass), 32'(to_abort), (pass == 1) ? 32'd0 : 32'd1);
      chk($sformatf("to mem p%0d pc_wen", pass), 32'(to_pc_wen), (pass == 1) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
